argmax_scanner: RTL and testbench

Sequential arg-max/arg-min selector for the routing datapath. It accepts a stream of unsigned 16-bit metric values (neighbour Q-values or residual energies), each tagged with a node ID. It tracks the best value under a fixed ordering and emits the winning value, its ID and the entry count once the stream's last beat has been accepted. It is the consumer side of the 16-bit magnitude comparison: it folds an unbounded sequence of comparisons into one registered decision for the next-hop selection logic.

---
 rtl/argmax_scanner.sv | 153 +++++++++++++++
 tb/tb_argmax_scanner.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_scanner.sv
// argmax_scanner
//   Sequential arg-max / arg-min selector. A scan is opened with a start
//   pulse, a stream of (value, id) beats is folded into a single running
//   best, and the winning value, its id and the number of accepted beats
//   are presented once the last beat of the stream has been accepted.
//
// Parameters
//   DATA_WIDTH : width of the unsigned metric value
//   ID_WIDTH   : width of the node ID tag
//   MODE       : 0 = keep the maximum, 1 = keep the minimum
//
// Ports
//   clk        : clock, rising edge
//   nrst       : asynchronous active-low reset
//   start      : begin a scan (only seen while idle)
//   abort      : cancel the scan in progress (only seen while scanning)
//   in_valid   : beat valid
//   in_ready   : scanner accepting beats (registered state only)
//   in_value   : metric value of the beat
//   in_id      : node ID of the beat
//   in_last    : final beat of the stream
//   out_valid  : result available (registered state only)
//   out_ready  : downstream consumes the result
//   best_value : winning metric (running value while scanning)
//   best_id    : ID of the winning beat
//   count      : number of beats accepted, saturating
module argmax_scanner #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_value,
  input  logic [ID_WIDTH-1:0]   in_id,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] best_value,
  output logic [ID_WIDTH-1:0]   best_id,
  output logic [ID_WIDTH:0]     count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ID_WIDTH:0] COUNT_MAX = '1;
  localparam logic [ID_WIDTH:0] COUNT_ONE = {{ID_WIDTH{1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   best_value_q, best_value_d;
  logic [ID_WIDTH-1:0]     best_id_q, best_id_d;
  logic [ID_WIDTH:0]       count_q, count_d;
  logic                    first_q, first_d;
  logic                    is_better;

  // Strict comparison: an equal value never displaces the held best, so
  // the earliest of several equal beats is the one reported.
  always_comb begin
    if (MODE == 0) begin
      is_better = (in_value > best_value_q);
    end else begin
      is_better = (in_value < best_value_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      best_value_q <= '0;
      best_id_q    <= '0;
      count_q      <= '0;
      first_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      best_value_q <= best_value_d;
      best_id_q    <= best_id_d;
      count_q      <= count_d;
      first_q      <= first_d;
    end
  end

  // Next-state and datapath update. Abort is checked before the accept so
  // a beat presented in the abort cycle leaves every register untouched.
  always_comb begin
    state_d      = state_q;
    best_value_d = best_value_q;
    best_id_d    = best_id_q;
    count_d      = count_q;
    first_d      = first_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          best_value_d = '0;
          best_id_d    = '0;
          count_d      = '0;
          first_d      = 1'b1;
        end
      end

      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (in_valid) begin
          // The first beat always wins because the cleared best is not a
          // real sample and must not take part in the comparison.
          if (first_q || is_better) begin
            best_value_d = in_value;
            best_id_d    = in_id;
          end
          first_d = 1'b0;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
          end
          if (in_last) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = (state_q == SCAN);
    out_valid = (state_q == DONE);
  end

  assign best_value = best_value_q;
  assign best_id    = best_id_q;
  assign count      = count_q;

endmodule

// File: tb/tb_argmax_scanner.sv
// tb_argmax_scanner
//   Drives a max-mode and a min-mode scanner from shared beat signals with
//   separate start inputs, comparing against hand-computed expectations.
module tb_argmax_scanner;

  logic        clk;
  logic        nrst;
  logic        start0;
  logic        start1;
  logic        abort;
  logic        in_valid;
  logic [15:0] in_value;
  logic [7:0]  in_id;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0;
  logic [15:0] best_value0;
  logic [7:0]  best_id0;
  logic [8:0]  count0;

  logic        in_ready1, out_valid1;
  logic [15:0] best_value1;
  logic [7:0]  best_id1;
  logic [8:0]  count1;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        sel;
    logic        begin_scan;
    logic [15:0] value;
    logic [7:0]  id;
    logic        last;
    logic [15:0] exp_value;
    logic [7:0]  exp_id;
    logic [8:0]  exp_count;
  } vec_t;

  vec_t vecs [11];

  argmax_scanner #(.DATA_WIDTH(16), .ID_WIDTH(8), .MODE(0)) dut_max (
    .clk(clk), .nrst(nrst), .start(start0), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready0), .in_value(in_value),
    .in_id(in_id), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .best_value(best_value0), .best_id(best_id0),
    .count(count0)
  );

  argmax_scanner #(.DATA_WIDTH(16), .ID_WIDTH(8), .MODE(1)) dut_min (
    .clk(clk), .nrst(nrst), .start(start1), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready1), .in_value(in_value),
    .in_id(in_id), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .best_value(best_value1), .best_id(best_id1),
    .count(count1)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string name, input logic sel,
                            input logic exp_ready, input logic exp_valid,
                            input logic [15:0] exp_value, input logic [7:0] exp_id,
                            input logic [8:0] exp_count);
    logic        r;
    logic        v;
    logic [15:0] bv;
    logic [7:0]  bi;
    logic [8:0]  bc;
    r  = sel ? in_ready1   : in_ready0;
    v  = sel ? out_valid1  : out_valid0;
    bv = sel ? best_value1 : best_value0;
    bi = sel ? best_id1    : best_id0;
    bc = sel ? count1      : count0;
    checkOutput({name, " in_ready"},   32'(r),  32'(exp_ready));
    checkOutput({name, " out_valid"},  32'(v),  32'(exp_valid));
    checkOutput({name, " best_value"}, 32'(bv), 32'(exp_value));
    checkOutput({name, " best_id"},    32'(bi), 32'(exp_id));
    checkOutput({name, " count"},      32'(bc), 32'(exp_count));
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic [7:0] id,
                               input logic last);
    in_valid = 1'b1;
    in_value = value;
    in_id    = id;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_value = 16'hDEAD;
    in_id    = 8'hEE;
  endtask

  task automatic startScan(input logic sel);
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic drain(input string name, input logic sel);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({name, " drain out_valid"}, 32'(sel ? out_valid1 : out_valid0), 32'd0);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nrst      = 1'b1;
    start0    = 1'b0;
    start1    = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_value  = 16'h0;
    in_id     = 8'h0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    //        sel   begin value     id     last  expv     expid  expcnt
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 8'd1,  1'b0, 16'h0010, 8'd1,  9'd1};
    vecs[1]  = '{1'b0, 1'b0, 16'h8000, 8'd2,  1'b0, 16'h8000, 8'd2,  9'd2};
    vecs[2]  = '{1'b0, 1'b0, 16'h7FFF, 8'd3,  1'b1, 16'h8000, 8'd2,  9'd3};
    vecs[3]  = '{1'b0, 1'b1, 16'h0005, 8'd4,  1'b0, 16'h0005, 8'd4,  9'd1};
    vecs[4]  = '{1'b0, 1'b0, 16'h0005, 8'd5,  1'b0, 16'h0005, 8'd4,  9'd2};
    vecs[5]  = '{1'b0, 1'b0, 16'h0005, 8'd6,  1'b1, 16'h0005, 8'd4,  9'd3};
    vecs[6]  = '{1'b1, 1'b1, 16'hFFFF, 8'd9,  1'b1, 16'hFFFF, 8'd9,  9'd1};
    vecs[7]  = '{1'b1, 1'b1, 16'h0300, 8'd1,  1'b0, 16'h0300, 8'd1,  9'd1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0002, 8'd7,  1'b0, 16'h0002, 8'd7,  9'd2};
    vecs[9]  = '{1'b1, 1'b0, 16'h0002, 8'd8,  1'b1, 16'h0002, 8'd7,  9'd3};
    vecs[10] = '{1'b0, 1'b1, 16'h0000, 8'h11, 1'b1, 16'h0000, 8'h11, 9'd1};

    // Reset state, asserted asynchronously before any clock edge.
    #2 nrst = 1'b0;
    #1;
    checkState("reset max", 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 9'd0);
    checkState("reset min", 1'b1, 1'b0, 1'b0, 16'h0, 8'h0, 9'd0);
    tick();
    tick();
    nrst = 1'b1;

    // Table-driven streams.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].begin_scan) begin
        startScan(vecs[i].sel);
        checkState($sformatf("vec%0d start", i), vecs[i].sel, 1'b1, 1'b0,
                   16'h0, 8'h0, 9'd0);
      end
      applyStimulus(vecs[i].value, vecs[i].id, vecs[i].last);
      checkState($sformatf("vec%0d", i), vecs[i].sel, !vecs[i].last, vecs[i].last,
                 vecs[i].exp_value, vecs[i].exp_id, vecs[i].exp_count);
      if (vecs[i].last) drain($sformatf("vec%0d", i), vecs[i].sel);
    end

    // Input backpressure: in_valid every other cycle, garbage on idle cycles.
    startScan(1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k % 2 == 0) begin
        in_valid = 1'b1;
        in_value = (k == 0) ? 16'h0010 : (k == 2) ? 16'h8000 : 16'h7FFF;
        in_id    = 8'(k / 2 + 1);
        in_last  = (k == 4);
      end else begin
        in_valid = 1'b0;
        in_value = 16'hFFFF;
        in_id    = 8'hEE;
        in_last  = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkState("gapped result", 1'b0, 1'b0, 1'b1, 16'h8000, 8'd2, 9'd3);

    // Output backpressure with a start pulse that must be ignored in DONE.
    for (int k = 0; k < 5; k++) begin
      start0 = (k == 2);
      tick();
      checkState($sformatf("hold%0d", k), 1'b0, 1'b0, 1'b1, 16'h8000, 8'd2, 9'd3);
    end
    start0 = 1'b0;

    // Start coincident with the consuming edge is ignored.
    out_ready = 1'b1;
    start0    = 1'b1;
    tick();
    out_ready = 1'b0;
    start0    = 1'b0;
    checkState("consume", 1'b0, 1'b0, 1'b0, 16'h8000, 8'd2, 9'd3);
    tick();
    checkOutput("no restart in_ready", 32'(in_ready0), 32'd0);

    // Abort coincident with a beat drops it and returns to IDLE.
    startScan(1'b0);
    checkState("abort start", 1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 9'd0);
    applyStimulus(16'h0100, 8'd1, 1'b0);
    applyStimulus(16'h0200, 8'd2, 1'b0);
    checkState("pre abort", 1'b0, 1'b1, 1'b0, 16'h0200, 8'd2, 9'd2);
    abort = 1'b1;
    applyStimulus(16'hFFFF, 8'd3, 1'b0);
    abort = 1'b0;
    checkState("aborted", 1'b0, 1'b0, 1'b0, 16'h0200, 8'd2, 9'd2);
    tick();
    checkOutput("aborted out_valid", 32'(out_valid0), 32'd0);
    startScan(1'b0);
    checkState("restart", 1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 9'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset between edges after three beats.
    startScan(1'b0);
    applyStimulus(16'h0010, 8'd1, 1'b0);
    applyStimulus(16'h8000, 8'd2, 1'b0);
    applyStimulus(16'h7FFF, 8'd3, 1'b0);
    checkState("pre reset", 1'b0, 1'b1, 1'b0, 16'h8000, 8'd2, 9'd3);
    #2 nrst = 1'b0;
    #1;
    checkState("async reset", 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, 9'd0);
    tick();
    nrst   = 1'b1;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    checkState("post reset start", 1'b0, 1'b1, 1'b0, 16'h0, 8'h0, 9'd0);
    applyStimulus(16'h0010, 8'd1, 1'b0);
    applyStimulus(16'h8000, 8'd2, 1'b0);
    applyStimulus(16'h7FFF, 8'd3, 1'b1);
    checkState("post reset result", 1'b0, 1'b0, 1'b1, 16'h8000, 8'd2, 9'd3);
    drain("post reset", 1'b0);

    // Count saturation at 511 with rising values.
    startScan(1'b0);
    for (int i = 0; i < 515; i++) begin
      in_valid = 1'b1;
      in_value = 16'(i);
      in_id    = 8'(i);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    checkState("saturate", 1'b0, 1'b1, 1'b0, 16'd514, 8'd2, 9'd511);
    applyStimulus(16'h0000, 8'h33, 1'b1);
    checkState("saturate last", 1'b0, 1'b0, 1'b1, 16'd514, 8'd2, 9'd511);
    drain("saturate", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
